nco_clken_gen: RTL
==================

NCO_CLKEN_GEN -- requirements
Module: nco_clken_gen

Interface
REQ-001 SHALL have parameter NUM_CH, default 3: number of independent output channels (1..8).
REQ-002 SHALL have parameter ACC_W, default 32: phase-accumulator and increment width (8..32).
REQ-003 SHALL have parameter LOCK_CYCLES, default 1024: settle time in refclk cycles before locked asserts (>=2).
REQ-004 SHALL have parameter DEFAULT_INC, default 2^(ACC_W-1): per-channel increment loaded at reset.
REQ-005 SHALL have port refclk, input, 1: sole clock, rising-edge.
REQ-006 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-007 SHALL have port enable, input, NUM_CH: per-channel run enable.
REQ-008 SHALL have port cfg_valid, input, 1: increment-write request.
REQ-009 SHALL have port cfg_ready, output, 1: increment-write accept.
REQ-010 SHALL have port cfg_ch, input, max(1,clog2(NUM_CH)): target channel.
REQ-011 SHALL have port cfg_inc, input, ACC_W: new increment.
REQ-012 SHALL have port outclk_en, output, NUM_CH: per-channel single-cycle clock-enable pulses.
REQ-013 SHALL have port outclk, output, NUM_CH: per-channel square clock (see Configuration).
REQ-014 SHALL have port locked, output, 1: all channels settled since last reset or reconfiguration.

Function
REQ-015 Per channel, when enable[ch]=1 and not being reconfigured, acc[ch] SHALL update to (acc[ch]+inc[ch]) mod 2^ACC_W each cycle.
REQ-016 outclk_en[ch] SHALL be registered: high for exactly the cycle after an accumulate whose ACC_W+1-bit sum carried out; otherwise low.
REQ-017 When enable[ch]=0, acc[ch] SHALL hold and outclk_en[ch] SHALL be 0 the next cycle.
REQ-018 inc[ch]=0 SHALL produce no pulses; inc[ch]=2^ACC_W-1 SHALL produce pulses on all but one of every 2^ACC_W enabled cycles.
REQ-019 Controller FSM states SETTLE, LOCKED, APPLY; locked=1 only in LOCKED; cfg_ready=1 in SETTLE and LOCKED, 0 in APPLY.
REQ-020 Handshake: transfer occurs on a cycle with cfg_valid=1 and cfg_ready=1; cfg_ch/cfg_inc SHALL be captured on that edge; FSM SHALL enter APPLY.
REQ-021 APPLY (exactly one cycle): inc[cfg_ch] SHALL be written, acc[cfg_ch] cleared to 0, outclk_en[cfg_ch] forced 0; lock counter cleared; next state SETTLE.
REQ-022 APPLY SHALL take precedence over accumulation for the target channel; other channels SHALL keep running undisturbed.
REQ-023 SETTLE SHALL count cycles; after LOCK_CYCLES cycles in SETTLE, FSM SHALL enter LOCKED (locked high on the following cycle).
REQ-024 A transfer accepted in SETTLE SHALL restart settling via APPLY; a transfer in LOCKED SHALL drop locked on the next cycle.
REQ-025 A transfer with cfg_ch>=NUM_CH SHALL be accepted, modify no channel, and leave FSM state and locked unchanged (no APPLY).

Reset
REQ-026 While rst=1: acc=0, inc=DEFAULT_INC, outclk_en=0, outclk=0, locked=0, cfg_ready=0, FSM=SETTLE, lock counter=0, all asynchronously.
REQ-027 cfg_ready SHALL rise on the first refclk edge after rst deasserts; settle count starts on that same edge.
REQ-028 Reset asserted mid-APPLY or mid-SETTLE SHALL discard the pending write; inc reverts to DEFAULT_INC.

Configuration
REQ-029 With macro NCO_CLKEN_SQUARE_EN defined, outclk[ch] SHALL be the registered MSB of acc[ch] (50%-duty square at inc/2^ACC_W x f_refclk).
REQ-030 Without NCO_CLKEN_SQUARE_EN, outclk SHALL be tied to 0 and no extra flops inferred; all other behaviour is identical.

Verification (NUM_CH=3, ACC_W=8, LOCK_CYCLES=16, DEFAULT_INC=128)
REQ-031 Release rst, enable=3'b111 -> each outclk_en pulses every 2nd cycle; cfg_ready high 1 cycle after release; locked high exactly 17 cycles after release.
REQ-032 In LOCKED write ch1 inc=64 -> cfg_ready low 1 cycle, locked low next cycle, ch1 pulses every 4 cycles from acc=0, ch0/ch2 unchanged, locked re-rises 17 cycles after APPLY.
REQ-033 ch2 inc=96, run 64 cycles -> exactly 24 pulses, pattern repeating every 8 cycles.
REQ-034 Write cfg_ch=3 inc=1 while LOCKED -> accepted, no channel change, locked stays 1.
REQ-035 Assert rst mid-SETTLE after writing ch0 inc=32 -> all outputs 0 immediately; after release ch0 pulses every 2 cycles (inc=128).
REQ-036 With NCO_CLKEN_SQUARE_EN, ch0 inc=32 -> outclk[0] period 8 cycles, high 4; without the macro outclk stays 0.

Source files
------------

// File: rtl/nco_clken_gen.sv
// nco_clken_gen: multi-channel NCO clock-enable generator.
// Each channel runs a phase accumulator. The carry out of each accumulate
// becomes a one-cycle clock-enable pulse. A small controller takes
// increment writes through a valid/ready port, applies each write in a
// dedicated cycle, and reports lock after a fixed settle time.
// Optional feature: define NCO_CLKEN_SQUARE_EN to drive outclk from each
// accumulator MSB. Otherwise outclk is tied low.
//
// Handshake (cfg port): a write transfers on a rising refclk edge where
// cfg_valid and cfg_ready are both 1. cfg_ch and cfg_inc are sampled on
// that edge. The master holds cfg_ch and cfg_inc stable while cfg_valid
// is high and cfg_ready is low. cfg_ready is low only during reset and
// during the single APPLY cycle.
module nco_clken_gen #(
  parameter int               NUM_CH      = 3,
  parameter int               ACC_W       = 32,
  parameter int               LOCK_CYCLES = 1024,
  parameter logic [ACC_W-1:0] DEFAULT_INC = {1'b1, {(ACC_W-1){1'b0}}},
  localparam int              CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              refclk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] enable,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [ACC_W-1:0]  cfg_inc,
  output logic [NUM_CH-1:0] outclk_en,
  output logic [NUM_CH-1:0] outclk,
  output logic              locked,
  output logic [1:0]        state_dbg
);

  localparam int CNT_W = $clog2(LOCK_CYCLES + 1);

  typedef enum logic [1:0] {
    SETTLE = 2'd0,
    LOCKED = 2'd1,
    APPLY  = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [CH_W-1:0]    pend_ch;
  logic [ACC_W-1:0]   pend_inc;
  logic               xfer;
  logic               ch_ok;

  assign xfer      = cfg_valid && cfg_ready;
  // Writes to a channel that does not exist are accepted and then dropped.
  assign ch_ok     = xfer && ({1'b0, cfg_ch} < (CH_W+1)'(NUM_CH));
  assign locked    = (state == LOCKED);
  assign state_dbg = state;

  // Next-state logic: count settle cycles; a valid write diverts to APPLY.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      SETTLE: begin
        if (ch_ok)
          state_nxt = APPLY;
        else if (cnt == CNT_W'(LOCK_CYCLES))
          state_nxt = LOCKED;
        else
          cnt_nxt = cnt + CNT_W'(1);
      end
      LOCKED: begin
        if (ch_ok)
          state_nxt = APPLY;
      end
      APPLY: begin
        state_nxt = SETTLE;
        cnt_nxt   = '0;
      end
      default: begin
        state_nxt = SETTLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Controller registers. cfg_ready is registered from the next state, so
  // it first rises on the first edge after reset release.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state     <= SETTLE;
      cnt       <= '0;
      cfg_ready <= 1'b0;
      pend_ch   <= '0;
      pend_inc  <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      cfg_ready <= (state_nxt != APPLY);
      if (ch_ok) begin
        pend_ch  <= cfg_ch;
        pend_inc <= cfg_inc;
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] inc;
    logic             pulse;
    logic [ACC_W:0]   sum;
    logic             apply_me;

    assign sum      = {1'b0, acc} + {1'b0, inc};
    assign apply_me = (state == APPLY) && (pend_ch == CH_W'(g));

    // Channel datapath: APPLY overrides accumulation for the target channel.
    always_ff @(posedge refclk or posedge rst) begin
      if (rst) begin
        acc   <= '0;
        inc   <= DEFAULT_INC;
        pulse <= 1'b0;
      end else if (apply_me) begin
        inc   <= pend_inc;
        acc   <= '0;
        pulse <= 1'b0;
      end else if (enable[g]) begin
        acc   <= sum[ACC_W-1:0];
        pulse <= sum[ACC_W];
      end else begin
        pulse <= 1'b0;
      end
    end

    assign outclk_en[g] = pulse;
`ifdef NCO_CLKEN_SQUARE_EN
    // The accumulator is already a register, so its MSB is a registered square.
    assign outclk[g] = acc[ACC_W-1];
`else
    assign outclk[g] = 1'b0;
`endif
  end

endmodule
